// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I control FSM: opcodes, state
// encoding and the datapath select encodings it drives.
package multicycle_controller_pkg;

    // Major opcodes the controller recognises; anything else is illegal.
    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_t;

    // Controller states; the encoding is also exported on state_o.
    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_UPPER    = 4'd9,
        S_ALUWB    = 4'd10,
        S_BRANCH   = 4'd11,
        S_JAL      = 4'd12,
        S_JALR1    = 4'd13,
        S_JALR2    = 4'd14,
        S_TRAP     = 4'd15
    } ctrl_state_t;

    // ALU operand A select
    localparam logic [1:0] SRCA_REG  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // alu_decoder operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Writeback result select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_wait_state(input ctrl_state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Counts consecutive stalled cycles of an open memory request and flags the
// cycle on which one more stall would exhaust the allowed budget.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic mem_ready,
    input  logic advance,
    output logic expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count;

    // Stall counter: restarts whenever the FSM moves to a new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (advance) begin
            count <= '0;
        end else if (waiting && !mem_ready) begin
            count <= count + CW'(1);
        end
    end

    assign expired = waiting && !mem_ready && (count == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback over one shared req/ready memory port.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int TRAP_ON_ILLEGAL = 1,
    parameter int MEM_TIMEOUT     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  opcode_t     opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [2:0]  imm_src,
    output logic [1:0]  src_a,
    output logic [1:0]  src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic        illegal,
    output logic        mem_err,
    output logic [3:0]  state_o
);

    ctrl_state_t state;
    ctrl_state_t next_state;
    logic        pc_update;
    logic        branch;
    logic        timeout_hit;

    // The stall timer only exists when a timeout budget is configured.
    if (MEM_TIMEOUT > 0) begin : g_timer
        mem_wait_timer #(
            .MEM_TIMEOUT(MEM_TIMEOUT)
        ) u_timer (
            .clk      (clk),
            .rst_n    (rst_n),
            .waiting  (is_wait_state(state)),
            .mem_ready(mem_ready),
            .advance  (next_state != state),
            .expired  (timeout_hit)
        );
    end else begin : g_no_timer
        assign timeout_hit = 1'b0;
    end

    // State register; reset drops every Moore output immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            if ((state == S_DECODE) && (next_state == S_TRAP)) begin
                illegal <= 1'b1;
            end
            if (timeout_hit) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        imm_src    = IMM_I;
        src_a      = SRCA_REG;
        src_b      = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;

        case (state)
            S_RESET: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req    = 1'b1;
                src_a      = SRCA_PC;
                src_b      = SRCB_FOUR;
                result_src = RES_ALURES;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_update  = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                end
            end
            S_DECODE: begin
                src_a   = SRCA_PC;
                src_b   = SRCB_IMM;
                imm_src = IMM_B;
                case (opcode)
                    OPC_LOAD, OPC_STORE: next_state = S_MEMADR;
                    OPC_OP:              next_state = S_EXEC_R;
                    OPC_OP_IMM:          next_state = S_EXEC_I;
                    OPC_BRANCH:          next_state = S_BRANCH;
                    OPC_JAL:             next_state = S_JAL;
                    OPC_JALR:            next_state = S_JALR1;
                    OPC_LUI, OPC_AUIPC:  next_state = S_UPPER;
                    default:             next_state = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                src_b = SRCB_IMM;
                if (opcode == OPC_STORE) begin
                    imm_src    = IMM_S;
                    next_state = S_MEMWRITE;
                end else begin
                    next_state = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                end
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    next_state = S_FETCH;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                end
            end
            S_EXEC_R: begin
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXEC_I: begin
                src_b      = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_UPPER: begin
                src_a      = (opcode == OPC_LUI) ? SRCA_ZERO : SRCA_PC;
                src_b      = SRCB_IMM;
                imm_src    = IMM_U;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_op     = ALUOP_BR;
                branch     = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                src_a      = SRCA_PC;
                src_b      = SRCB_FOUR;
                imm_src    = IMM_J;
                pc_update  = 1'b1;
                next_state = S_ALUWB;
            end
            S_JALR1: begin
                src_b      = SRCB_IMM;
                next_state = S_JALR2;
            end
            S_JALR2: begin
                src_a      = SRCA_PC;
                src_b      = SRCB_FOUR;
                pc_update  = 1'b1;
                next_state = S_ALUWB;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_RESET;
            end
        endcase
    end

    assign pc_write = pc_update | (branch & branch_taken);
    assign state_o  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised bench for multicycle_controller: two instances (trapping with
// an 8-cycle timeout, and non-trapping without timeout) share one stimulus.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [2:0] imm_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic [3:0] state;
    } ctrl_t;

    typedef struct {
        ctrl_t c;
        bit    waits;
    } step_t;

    typedef step_t step_q_t[$];

    logic    clk = 1'b0;
    logic    rst_n;
    opcode_t opcode;
    logic    branch_taken;
    logic    mem_ready;

    logic a_mem_req, a_mem_we, a_adr_src, a_ir_write, a_pc_write, a_reg_write;
    logic [2:0] a_imm_src;
    logic [1:0] a_src_a, a_src_b, a_alu_op, a_result_src;
    logic a_illegal, a_mem_err;
    logic [3:0] a_state_o;
    logic b_mem_req, b_mem_we, b_adr_src, b_ir_write, b_pc_write, b_reg_write;
    logic [2:0] b_imm_src;
    logic [1:0] b_src_a, b_src_b, b_alu_op, b_result_src;
    logic b_illegal, b_mem_err;
    logic [3:0] b_state_o;

    ctrl_t obs_a, obs_b;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign obs_a = {a_mem_req, a_mem_we, a_adr_src, a_ir_write, a_pc_write, a_reg_write,
                    a_imm_src, a_src_a, a_src_b, a_alu_op, a_result_src, a_state_o};
    assign obs_b = {b_mem_req, b_mem_we, b_adr_src, b_ir_write, b_pc_write, b_reg_write,
                    b_imm_src, b_src_a, b_src_b, b_alu_op, b_result_src, b_state_o};

    multicycle_controller #(.TRAP_ON_ILLEGAL(1), .MEM_TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(a_mem_req), .mem_we(a_mem_we), .adr_src(a_adr_src),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .reg_write(a_reg_write),
        .imm_src(a_imm_src), .src_a(a_src_a), .src_b(a_src_b), .alu_op(a_alu_op),
        .result_src(a_result_src), .illegal(a_illegal), .mem_err(a_mem_err), .state_o(a_state_o)
    );

    multicycle_controller #(.TRAP_ON_ILLEGAL(0), .MEM_TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(b_mem_req), .mem_we(b_mem_we), .adr_src(b_adr_src),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .reg_write(b_reg_write),
        .imm_src(b_imm_src), .src_a(b_src_a), .src_b(b_src_b), .alu_op(b_alu_op),
        .result_src(b_result_src), .illegal(b_illegal), .mem_err(b_mem_err), .state_o(b_state_o)
    );

    // Build one expected control word from the per-state tables.
    function automatic ctrl_t mk(input ctrl_state_t st, input logic req, input logic we,
                                 input logic adr, input logic irw, input logic pcw,
                                 input logic rw, input logic [2:0] imm, input logic [1:0] sa,
                                 input logic [1:0] sb, input logic [1:0] aop,
                                 input logic [1:0] res);
        ctrl_t c;
        c = {req, we, adr, irw, pcw, rw, imm, sa, sb, aop, res, st};
        return c;
    endfunction

    // Reference model: the cycle-by-cycle plan an instruction should follow.
    function automatic step_q_t build_plan(input opcode_t op);
        step_q_t q;
        ctrl_t   wb;
        wb = mk(S_ALUWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00);
        q.push_back('{c: mk(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 2'b01, 2'b10, 2'b00, 2'b10), waits: 1'b1});
        q.push_back('{c: mk(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 2'b01, 2'b01, 2'b00, 2'b00), waits: 1'b0});
        case (op)
            OPC_LOAD: begin
                q.push_back('{c: mk(S_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b01, 2'b00, 2'b00), waits: 1'b0});
                q.push_back('{c: mk(S_MEMREAD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00), waits: 1'b1});
                q.push_back('{c: mk(S_MEMWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01), waits: 1'b0});
            end
            OPC_STORE: begin
                q.push_back('{c: mk(S_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 2'b00, 2'b01, 2'b00, 2'b00), waits: 1'b0});
                q.push_back('{c: mk(S_MEMWRITE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00), waits: 1'b1});
            end
            OPC_OP: begin
                q.push_back('{c: mk(S_EXEC_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 2'b10, 2'b00), waits: 1'b0});
                q.push_back('{c: wb, waits: 1'b0});
            end
            OPC_OP_IMM: begin
                q.push_back('{c: mk(S_EXEC_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b01, 2'b10, 2'b00), waits: 1'b0});
                q.push_back('{c: wb, waits: 1'b0});
            end
            OPC_BRANCH: begin
                q.push_back('{c: mk(S_BRANCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 2'b01, 2'b00), waits: 1'b0});
            end
            OPC_JAL: begin
                q.push_back('{c: mk(S_JAL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 2'b01, 2'b10, 2'b00, 2'b00), waits: 1'b0});
                q.push_back('{c: wb, waits: 1'b0});
            end
            OPC_JALR: begin
                q.push_back('{c: mk(S_JALR1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b01, 2'b00, 2'b00), waits: 1'b0});
                q.push_back('{c: mk(S_JALR2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 2'b01, 2'b10, 2'b00, 2'b00), waits: 1'b0});
                q.push_back('{c: wb, waits: 1'b0});
            end
            OPC_LUI: begin
                q.push_back('{c: mk(S_UPPER, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 2'b10, 2'b01, 2'b00, 2'b00), waits: 1'b0});
                q.push_back('{c: wb, waits: 1'b0});
            end
            default: begin
                q.push_back('{c: mk(S_UPPER, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 2'b01, 2'b01, 2'b00, 2'b00), waits: 1'b0});
                q.push_back('{c: wb, waits: 1'b0});
            end
        endcase
        return q;
    endfunction

    // Hold reset across one rising edge and release it; FETCH follows one edge later.
    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one legal instruction through both DUTs, checking every cycle.
    // fw/mw: stall cycles in fetch/memory (negative = random 0..7).
    task automatic exec_instr(input opcode_t op, input int fw, input int mw,
                              input int taken_mode, output int cycles);
        step_q_t plan;
        ctrl_t   exp;
        int      n;
        plan   = build_plan(op);
        cycles = 0;
        opcode = op;
        foreach (plan[i]) begin
            n = 0;
            if (plan[i].waits) begin
                n = (plan[i].c.state == 4'(S_FETCH)) ? fw : mw;
                if (n < 0) n = int'($urandom_range(0, 7));
            end
            for (int k = 0; k <= n; k++) begin
                @(negedge clk);
                mem_ready    = plan[i].waits ? (k == n) : 1'($urandom_range(0, 1));
                branch_taken = (taken_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(taken_mode);
                #1;
                exp = plan[i].c;
                if (plan[i].waits && !mem_ready) begin
                    exp.ir_write = 1'b0;
                    exp.pc_write = 1'b0;
                end
                if (exp.state == 4'(S_BRANCH)) exp.pc_write = branch_taken;
                checks++;
                if (obs_a !== exp) begin
                    errors++;
                    $display("[TB] FAIL %s cyc%0d dut_a got %h expected %h", op.name(), cycles, obs_a, exp);
                end
                checks++;
                if (obs_b !== exp) begin
                    errors++;
                    $display("[TB] FAIL %s cyc%0d dut_b got %h expected %h", op.name(), cycles, obs_b, exp);
                end
                cycles++;
            end
        end
        checks++;
        if ({a_illegal, a_mem_err, b_illegal, b_mem_err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL %s flags got %b expected 0000", op.name(),
                     {a_illegal, a_mem_err, b_illegal, b_mem_err});
        end
    endtask

    task automatic test_reset();
        ctrl_t rst_c, fetch_c;
        rst_c   = mk(S_RESET, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00);
        fetch_c = mk(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b01, 2'b10, 2'b00, 2'b10);
        rst_n = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1; opcode = OPC_OP;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_a !== rst_c || obs_b !== rst_c) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h/%h expected %h", obs_a, obs_b, rst_c);
        end
        checks++;
        if ({a_illegal, a_mem_err, b_illegal, b_mem_err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b expected 0000", {a_illegal, a_mem_err, b_illegal, b_mem_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs_a !== rst_c) begin
            errors++;
            $display("[TB] FAIL reset_release got %h expected %h", obs_a, rst_c);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (obs_a !== fetch_c || obs_b !== fetch_c) begin
            errors++;
            $display("[TB] FAIL reset_to_fetch got %h/%h expected %h", obs_a, obs_b, fetch_c);
        end
    endtask

    task automatic test_op_load();
        int cyc;
        do_reset();
        exec_instr(OPC_OP, 0, 0, -1, cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("[TB] FAIL op_cycles got %0d expected 4", cyc);
        end
        exec_instr(OPC_LOAD, 2, 3, -1, cyc);
        checks++;
        if (cyc != 10) begin
            errors++;
            $display("[TB] FAIL load_cycles got %0d expected 10", cyc);
        end
        exec_instr(OPC_STORE, 1, 2, -1, cyc);
        exec_instr(OPC_OP_IMM, 0, 0, -1, cyc);
    endtask

    task automatic test_upper_branch_jump();
        int cyc;
        do_reset();
        exec_instr(OPC_LUI, 0, 0, -1, cyc);
        exec_instr(OPC_AUIPC, 1, 0, -1, cyc);
        exec_instr(OPC_BRANCH, 0, 0, 0, cyc);
        exec_instr(OPC_BRANCH, 0, 0, 1, cyc);
        exec_instr(OPC_JALR, 0, 0, -1, cyc);
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("[TB] FAIL jalr_cycles got %0d expected 5", cyc);
        end
        exec_instr(OPC_JAL, 0, 0, -1, cyc);
    endtask

    task automatic test_random();
        opcode_t legal[9] = '{OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_BRANCH,
                              OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
        int cyc;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            exec_instr(legal[$urandom_range(0, 8)], -1, -1, -1, cyc);
        end
    endtask

    task automatic test_timeout();
        ctrl_t fetch_c, trap_c;
        int    cyc;
        fetch_c = mk(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b01, 2'b10, 2'b00, 2'b10);
        trap_c  = mk(S_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00);
        do_reset();
        exec_instr(OPC_OP, 7, 0, -1, cyc);
        checks++;
        if (cyc != 11) begin
            errors++;
            $display("[TB] FAIL timeout_edge_cycles got %0d expected 11", cyc);
        end
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            checks++;
            if (obs_a !== fetch_c) begin
                errors++;
                $display("[TB] FAIL timeout_wait%0d got %h expected %h", k, obs_a, fetch_c);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs_a !== trap_c || a_mem_err !== 1'b1 || a_illegal !== 1'b0) begin
                errors++;
                $display("[TB] FAIL timeout_trap got %h err %b ill %b expected %h err 1 ill 0",
                         obs_a, a_mem_err, a_illegal, trap_c);
            end
            checks++;
            if (k == 0 && (obs_b !== fetch_c || b_mem_err !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL no_timeout got %h err %b expected %h err 0", obs_b, b_mem_err, fetch_c);
            end
            mem_ready = 1'b1;
        end
    endtask

    task automatic test_illegal();
        ctrl_t fetch_c, trap_c;
        fetch_c = mk(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b01, 2'b10, 2'b00, 2'b10);
        trap_c  = mk(S_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00);
        do_reset();
        opcode = opcode_t'(7'b0000000);
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        #1;
        checks++;
        if (a_state_o !== 4'(S_DECODE) || b_state_o !== 4'(S_DECODE)) begin
            errors++;
            $display("[TB] FAIL illegal_decode got %0d/%0d expected %0d", a_state_o, b_state_o, 4'(S_DECODE));
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            opcode = OPC_OP;
            #1;
            checks++;
            if (obs_a !== trap_c || a_illegal !== 1'b1 || a_mem_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL illegal_trap got %h ill %b expected %h ill 1", obs_a, a_illegal, trap_c);
            end
            checks++;
            if (k == 0 && (obs_b !== fetch_c || b_illegal !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL illegal_nop got %h ill %b expected %h ill 0", obs_b, b_illegal, fetch_c);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [3:0] path[4] = '{4'(S_FETCH), 4'(S_DECODE), 4'(S_MEMADR), 4'(S_MEMWRITE)};
        do_reset();
        opcode = OPC_STORE;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ready = (k == 0);
            #1;
            checks++;
            if (a_state_o !== path[k]) begin
                errors++;
                $display("[TB] FAIL store_path%0d got %0d expected %0d", k, a_state_o, path[k]);
            end
        end
        checks++;
        if ({a_mem_req, a_mem_we, b_mem_req, b_mem_we} !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL write_req got %b expected 1111", {a_mem_req, a_mem_we, b_mem_req, b_mem_we});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_mem_req, a_mem_we, b_mem_req, b_mem_we} !== 4'b0000 || a_state_o !== 4'(S_RESET)) begin
            errors++;
            $display("[TB] FAIL async_drop got %b state %0d expected 0000 state 0",
                     {a_mem_req, a_mem_we, b_mem_req, b_mem_we}, a_state_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (a_state_o !== 4'(S_FETCH) || b_state_o !== 4'(S_FETCH)) begin
            errors++;
            $display("[TB] FAIL resume_fetch got %0d/%0d expected %0d", a_state_o, b_state_o, 4'(S_FETCH));
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        opcode       = OPC_OP;
        test_reset();
        test_op_load();
        test_upper_branch_jump();
        test_random();
        test_timeout();
        test_illegal();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
